gan_result_streamer: RTL and testbench
======================================

# gan_result_streamer

Result-side companion to `GAN_shared_hw`. It tracks the shared-hardware GAN's fixed compute latency from `Start`, then captures the four 32-bit signed outputs `f1`..`f4`. It emits them as one framed byte stream over a valid/ready handshake toward the host/UART side of the design. It is the reader of the GAN result interface and is driven by the same `Start` that launches the GAN.

## Interface
Parameters:
- `LATENCY`, default 40: clock cycles from the detected `Start` rising edge to the capture of `f1`..`f4`. Legal range is 1..255.
- `HDR`, default 8'hA5: frame header byte.

Ports:
- `Clock`  in  1: single clock, rising edge.
- `Reset`  in  1: reset, asynchronous and active-low.
- `Start`  in  1: same signal that launches `GAN_shared_hw`. Level-held by the driver.
- `f1`, `f2`, `f3`, `f4`  in  32 each: signed GAN outputs, two's complement.
- `tx_data`  out  8: current stream byte.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: sink accepts the byte.
- `tx_last`  out  1: high together with the final (checksum) byte.
- `Busy`  out  1: high in any state other than IDLE.
- `Overrun`  out  1: sticky. Set when a `Start` rising edge arrives while `Busy` is high.

## Operation
- Start detection uses a registered copy `start_q`. A trigger is `Start & ~start_q`.
- States:
  - **IDLE**: on a trigger, go to WAIT and load `cnt` with 1.
  - **WAIT**: `cnt` increments each cycle.
    - If `Start` is low, abort to IDLE. No capture, no output.
    - If `cnt == LATENCY`, capture `f1`..`f4` into `cap[0..3]`, clear the checksum, and go to HDR.
  - **HDR**: present `HDR` on `tx_data`. On transfer, go to DATA with `idx` = 0.
  - **DATA**: present byte `idx` (0..15).
    - Byte order: `f1` first, then `f2`, `f3`, `f4`. Within each word, MSB byte first.
    - On each transfer, XOR the byte into `csum` and increment `idx`.
    - After the transfer of `idx` = 15, go to CSUM.
  - **CSUM**: present `csum` (the XOR of the 16 data bytes; the header is excluded) with `tx_last` = 1. On transfer, go to IDLE.
- A transfer happens on a rising edge where `tx_valid & tx_ready`.
- Handshake rules:
  - `tx_valid` is high exactly in HDR, DATA and CSUM.
  - While `tx_valid & ~tx_ready`, `tx_data` and `tx_last` hold stable.
  - `tx_valid` never drops without a transfer.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- Captured values are frozen. Changes on `f1`..`f4` after capture do not affect the frame.
- Negative results are sent as raw two's-complement bytes. There is no saturation.
- Trigger while `Busy`: it is ignored, the current frame continues unchanged, and `Overrun` sets. Only `Reset` clears `Overrun`.
- A trigger in the same cycle as the final CSUM transfer counts as arriving while `Busy`: it is ignored and sets `Overrun`.

## Timing
- Reset values:
  - `tx_data` = 0, `tx_valid` = 0, `tx_last` = 0, `Busy` = 0, `Overrun` = 0.
  - State = IDLE, `start_q` = 0, `cnt` = 0, `idx` = 0, `csum` = 0.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously) and the frame is discarded. Sinks must tolerate a truncated frame without `tx_last`.
- Cycle numbering: edge 0 is the edge where the trigger is sampled. `Busy` is high after edge 0.
- `f1`..`f4` are sampled at edge `LATENCY`. `tx_valid` rises with the header after edge `LATENCY`.
- With `tx_ready` held high:
  - One byte transfers per cycle; the frame is 18 bytes.
  - The last transfer is at edge `LATENCY` + 18.
  - `Busy` falls after that edge.
- With default `LATENCY` = 40, captures land exactly 400 time units after `Start` at a 10-unit clock, matching the GAN bench timing.
- Back-pressure: each low cycle of `tx_ready` adds exactly one cycle. There is no byte loss or duplication.

## Structure
- Shared package `gan_stream_pkg`:
  - state enum (IDLE, WAIT, HDR, DATA, CSUM);
  - `FRAME_BYTES` = 18;
  - `DATA_BYTES` = 16;
  - default header 8'hA5.
- Single module, no sub-modules.
- The byte mux is `cap[idx[3:2]]` sliced by `idx[1:0]`, MSB first.
- The module is top-level-instantiable next to `GAN_shared_hw`, sharing `Clock`, `Reset` and `Start`.

## Test plan
- **Golden frame**: `f1` = 162628187 (32'h09B1825B), `tx_ready` = 1. Expected response:
  - bytes A5, 09, B1, 82, 5B, ... in order;
  - the first byte appears after edge 40;
  - `tx_last` only on byte 18.
- **Checksum**: `f1` = 32'h01020304, `f2` = 32'h05060708, `f3` = 0, `f4` = -1. Expected: data bytes 01..08, 00×4, FF×4, then checksum 08.
- **Back-pressure**: toggle `tx_ready` pseudo-randomly. Expected:
  - `tx_data` is stable whenever valid and not ready;
  - the 18 bytes are identical to the no-stall run;
  - total cycles equal 18 plus the number of stall cycles.
- **Overrun and abort**:
  - Pulse `Start` low then high in the middle of DATA. Expected: the frame is unchanged and `Overrun` = 1 until `Reset`.
  - Drop `Start` at cycle 20 of WAIT. Expected: no `tx_valid`, and `Busy` is low next cycle.
- **Reset mid-frame**: assert `Reset` low during byte 7. Expected:
  - all outputs are 0 immediately;
  - after release, a new `Start` yields a complete correct frame.
- **Capture freeze**: change `f1`..`f4` one cycle after capture. Expected: the frame carries the captured values.

Source files
------------

// File: rtl/gan_stream_pkg.sv
// Shared definitions for the GAN result byte streamer.
package gan_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam int         FRAME_BYTES = 18;
  localparam int         DATA_BYTES  = 16;
  localparam logic [7:0] DEFAULT_HDR = 8'hA5;

  // Select one byte of a 32-bit word, sel 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gan_result_streamer.sv
// Waits out the GAN compute latency after Start, captures f1..f4 and streams
// them as HDR + 16 data bytes + XOR checksum over a valid/ready handshake.
module gan_result_streamer
  import gan_stream_pkg::*;
#(
  parameter int         LATENCY = 40,
  parameter logic [7:0] HDR     = DEFAULT_HDR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] f1,
  input  logic [31:0] f2,
  input  logic [31:0] f3,
  input  logic [31:0] f4,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        Busy,
  output logic        Overrun
);

  localparam logic [7:0] LAT8     = 8'(LATENCY);
  localparam logic [3:0] LAST_IDX = 4'(DATA_BYTES - 1);

  state_t      state_reg, state_next;
  logic        start_q;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic [7:0]  csum_reg, csum_next;
  logic [31:0] cap_reg [4];
  logic [31:0] f_in [4];
  logic        overrun_reg;
  logic        capture;
  logic        trigger;
  logic [7:0]  data_byte;

  assign f_in[0] = f1;
  assign f_in[1] = f2;
  assign f_in[2] = f3;
  assign f_in[3] = f4;

  assign trigger   = Start & ~start_q;
  assign Busy      = (state_reg != ST_IDLE);
  assign Overrun   = overrun_reg;
  assign data_byte = word_byte(cap_reg[idx_reg[3:2]], idx_reg[1:0]);

  // State, counters, checksum, start edge detector and sticky overrun flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ST_IDLE;
      start_q     <= 1'b0;
      cnt_reg     <= 8'd0;
      idx_reg     <= 4'd0;
      csum_reg    <= 8'd0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_q     <= Start;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      csum_reg    <= csum_next;
      // A trigger is only honoured in IDLE; anything else is an overrun.
      overrun_reg <= overrun_reg | (trigger & Busy);
    end
  end

  // Result capture: frozen once taken so later GAN activity cannot corrupt the frame.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) cap_reg[i] <= 32'd0;
    end else if (capture) begin
      for (int i = 0; i < 4; i++) cap_reg[i] <= f_in[i];
    end
  end

  // Next-state and stream outputs; tx_valid depends on state only, never on tx_ready.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    capture    = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    tx_data    = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (trigger) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (!Start) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == LAT8) begin
          capture    = 1'b1;
          csum_next  = 8'd0;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR;
        if (tx_ready) begin
          state_next = ST_DATA;
          idx_next   = 4'd0;
        end
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
          csum_next = csum_reg ^ data_byte;
          idx_next  = idx_reg + 4'd1;
          if (idx_reg == LAST_IDX) state_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = csum_reg;
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gan_result_streamer.sv
// Randomised scoreboard bench for gan_result_streamer: stimulus pushes the
// expected frame, a negedge monitor pops and compares every transferred byte.
module tb_gan_result_streamer;
  import gan_stream_pkg::*;

  localparam int         LAT  = 40;
  localparam logic [7:0] HDRB = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] f1 = '0, f2 = '0, f3 = '0, f4 = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_ovr  = 1'b0;

  logic [8:0] exp_q[$];      // {last, data}
  logic [7:0] exp_frame [FRAME_BYTES];

  // monitor state for the hold-stable rule
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  gan_result_streamer #(.LATENCY(LAT), .HDR(HDRB)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start),
    .f1(f1), .f2(f2), .f3(f3), .f4(f4),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .Busy(busy), .Overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, the four words big-endian, XOR of the data bytes.
  task automatic model_frame(input logic [31:0] a, b, c, d);
    logic [31:0] w [4];
    logic [7:0]  cs;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    cs = 8'h00;
    exp_frame[0] = HDRB;
    for (int k = 0; k < DATA_BYTES; k++) begin
      exp_frame[k + 1] = 8'((w[k / 4] >> (24 - 8 * (k % 4))) & 32'hFF);
      cs ^= exp_frame[k + 1];
    end
    exp_frame[FRAME_BYTES - 1] = cs;
    for (int k = 0; k < FRAME_BYTES; k++)
      exp_q.push_back({(k == FRAME_BYTES - 1), exp_frame[k]});
  endtask

  // Monitor: inputs change 1 time unit after posedge, so negedge sees exactly
  // what the next posedge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data",  {24'd0, tx_data},  {24'd0, hold_data});
        chk("hold_last",  {31'd0, tx_last},  {31'd0, hold_last});
      end
      hold_pending = tx_valid && !tx_ready;
      hold_data    = tx_data;
      hold_last    = tx_last;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, tx_last, tx_data}, 32'hDEAD);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("byte_data", {24'd0, tx_data}, {24'd0, e[7:0]});
          chk("byte_last", {31'd0, tx_last}, {31'd0, e[8]});
        end
      end
    end
  end

  // One full frame from Start; optional random stalls, overrun poke, input change.
  task automatic run_frame(input logic [31:0] a, b, c, d, input bit rnd_ready,
                           input bit poke_start, input bit change_f, input string tag);
    int e, stalls, first_valid;
    bit done;
    f1 = a; f2 = b; f3 = c; f4 = d;
    model_frame(a, b, c, d);
    start = 1'b1;
    e = 0; stalls = 0; first_valid = -1; done = 1'b0;
    while (!done && e < LAT + FRAME_BYTES + 400) begin
      tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (tx_valid && !tx_ready) stalls++;
      if (poke_start && e == LAT + 6) start = 1'b0;
      if (poke_start && e == LAT + 7) start = 1'b1;
      if (change_f && e == LAT + 1) begin
        f1 = $urandom; f2 = $urandom; f3 = $urandom; f4 = $urandom;
      end
      @(posedge clk); #1;
      if (e == 0) chk({tag, "_busy_edge0"}, {31'd0, busy}, 32'd1);
      if (tx_valid && first_valid < 0) first_valid = e;
      if (!busy) done = 1'b1;
      else e++;
    end
    if (poke_start) exp_ovr = 1'b1;
    chk({tag, "_first_valid_edge"}, first_valid, LAT);
    chk({tag, "_last_edge"}, e, LAT + FRAME_BYTES + stalls);
    chk({tag, "_all_bytes_seen"}, exp_q.size(), 0);
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    $display("frame %s: f=%08h %08h %08h %08h csum=%02h stalls=%0d", tag, a, b, c, d,
             exp_frame[FRAME_BYTES - 1], stalls);
    start = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb, rc, rd;
    #1;
    chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_last",  {31'd0, tx_last}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_overrun",  {31'd0, overrun}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // golden and checksum frames with tx_ready held high
    ra = $urandom; rb = $urandom; rc = $urandom;
    run_frame(32'h09B1825B, ra, rb, rc, 1'b0, 1'b0, 1'b0, "golden");
    run_frame(32'h01020304, 32'h05060708, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "csum");

    // same golden payload under back-pressure, then random payloads
    run_frame(32'h09B1825B, ra, rb, rc, 1'b1, 1'b0, 1'b0, "golden_bp");
    for (int i = 0; i < 4; i++) begin
      run_frame($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0, "random_bp");
    end

    // inputs change right after capture
    run_frame($urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1, "freeze");

    // Start re-pulsed during DATA: frame unaffected, overrun sticky afterwards
    run_frame($urandom, $urandom, $urandom, $urandom, 1'b0, 1'b1, 1'b0, "overrun");
    run_frame($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0, "after_ovr");

    // abort: Start dropped at edge 20 of WAIT
    begin
      bit saw_valid;
      saw_valid = 1'b0;
      start = 1'b1;
      for (int e = 0; e <= 20; e++) begin
        tx_ready = 1'b1;
        if (e == 20) start = 1'b0;
        @(posedge clk); #1;
        if (tx_valid) saw_valid = 1'b1;
      end
      chk("abort_busy_low", {31'd0, busy}, 32'd0);
      repeat (LAT + 5) begin
        @(posedge clk); #1;
        if (tx_valid) saw_valid = 1'b1;
      end
      chk("abort_no_valid", {31'd0, saw_valid}, 32'd0);
      chk("abort_overrun_kept", {31'd0, overrun}, {31'd0, exp_ovr});
      $display("abort: Start dropped at WAIT edge 20");
      tx_ready = 1'b0;
    end

    // reset asserted while data byte 7 is on the bus
    begin
      model_frame($urandom, $urandom, $urandom, $urandom);
      f1 = 32'h0; // ensure the values below come from the model call
      f1 = {exp_frame[1], exp_frame[2], exp_frame[3], exp_frame[4]};
      f2 = {exp_frame[5], exp_frame[6], exp_frame[7], exp_frame[8]};
      f3 = {exp_frame[9], exp_frame[10], exp_frame[11], exp_frame[12]};
      f4 = {exp_frame[13], exp_frame[14], exp_frame[15], exp_frame[16]};
      start = 1'b1;
      for (int e = 0; e <= LAT + 8; e++) begin
        tx_ready = 1'b1;
        @(posedge clk); #1;
      end
      chk("midrst_byte7_valid", {31'd0, tx_valid}, 32'd1);
      chk("midrst_byte7_data", {24'd0, tx_data}, {24'd0, exp_frame[8]});
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_data",  {24'd0, tx_data}, 32'd0);
      chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("midrst_tx_last",  {31'd0, tx_last}, 32'd0);
      chk("midrst_busy",     {31'd0, busy}, 32'd0);
      chk("midrst_overrun",  {31'd0, overrun}, 32'd0);
      exp_q.delete();
      exp_ovr = 1'b0;
      start = 1'b0;
      tx_ready = 1'b0;
      $display("reset asserted during data byte 7");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end

    run_frame($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0, "post_reset");

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
